// File: rtl/adc_avg_fifo.sv
// Block averager (2^k samples per result) feeding a first-word-fall-through result FIFO with threshold flagging.
// Optional out-of-window detection is compiled in with the ADC_AVG_WINDOW_EN macro.
`timescale 1ns/1ps
module adc_avg_fifo #(
   parameter int DW       = 12,
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int MAX_LOG2 = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          flush,
   input  logic [2:0]    avg_log2,
   input  logic [DW-1:0] threshold,
`ifdef ADC_AVG_WINDOW_EN
   input  logic [DW-1:0] threshold_lo,
   output logic          win_hit,
`endif
   input  logic          sample_valid,
   input  logic [DW-1:0] sample_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          overflow,
   output logic          thr_hit,
   output logic          avg_busy
);

   localparam int ACCW = DW + MAX_LOG2;
   localparam int CW   = MAX_LOG2 + 1;

   typedef enum logic {IDLE, ACC} state_t;

   state_t          state_q, state_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      k_q, k_d;
   logic [ACCW-1:0] sum;
   logic [CW-1:0]   cnt_inc;
   logic [CW-1:0]   blk_len;
   logic            res_valid;
   logic [DW-1:0]   res_data;

   assign sum     = acc_q + ACCW'(sample_data);
   assign cnt_inc = cnt_q + CW'(1);
   assign blk_len = CW'(1) << k_q;

   // Result is formed combinationally in the final sample's cycle so the push lands on that same edge.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      res_valid = 1'b0;
      res_data  = '0;
      if (flush || !en) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sample_valid) begin
                  k_d = avg_log2;
                  if (avg_log2 == 3'd0) begin
                     res_valid = 1'b1;
                     res_data  = sample_data;
                  end else begin
                     state_d = ACC;
                     acc_d   = ACCW'(sample_data);
                     cnt_d   = CW'(1);
                  end
               end
            end
            ACC: begin
               if (sample_valid) begin
                  if (cnt_inc == blk_len) begin
                     res_valid = 1'b1;
                     res_data  = DW'(sum >> k_q);
                     state_d   = IDLE;
                     acc_d     = '0;
                     cnt_d     = '0;
                  end else begin
                     acc_d = sum;
                     cnt_d = cnt_inc;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
      end
   end

   assign avg_busy = (state_q == ACC);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          overflow_q, overflow_d, thr_hit_q, thr_hit_d;
   logic          do_pop, push_ok, drop;

   // A pop against a full FIFO frees the slot the coincident push needs; an empty FIFO has nothing to pop.
   assign do_pop  = rd_en && !empty_q && !flush;
   assign push_ok = res_valid && (!full_q || do_pop);
   assign drop    = res_valid && full_q && !do_pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + AW'(push_ok);
      rd_ptr_d   = rd_ptr_q + AW'(do_pop);
      level_d    = level_q + (AW+1)'(push_ok) - (AW+1)'(do_pop);
      overflow_d = overflow_q | drop;
      thr_hit_d  = push_ok && (res_data >= threshold);
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         thr_hit_d  = 1'b0;
      end
      full_d  = (level_d == (AW+1)'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         thr_hit_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         overflow_q <= overflow_d;
         thr_hit_q  <= thr_hit_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= res_data;
      end
   end

   assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
   assign empty    = empty_q;
   assign full     = full_q;
   assign level    = level_q;
   assign overflow = overflow_q;
   assign thr_hit  = thr_hit_q;

`ifdef ADC_AVG_WINDOW_EN
   logic win_hit_q, win_hit_d;

   assign win_hit_d = !flush && push_ok && ((res_data < threshold_lo) || (res_data >= threshold));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_hit_q <= 1'b0;
      end else begin
         win_hit_q <= win_hit_d;
      end
   end

   assign win_hit = win_hit_q;
`endif

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Directed self-checking bench for adc_avg_fifo: averaging, FIFO boundaries, flush and async reset.
`timescale 1ns/1ps
module tb_adc_avg_fifo;
   localparam int DW = 12;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n, en, flush, sample_valid, rd_en;
   logic [2:0]    avg_log2;
   logic [DW-1:0] threshold, sample_data, rd_data;
   logic          empty, full, overflow, thr_hit, avg_busy;
   logic [AW:0]   level;
`ifdef ADC_AVG_WINDOW_EN
   logic [DW-1:0] threshold_lo;
   logic          win_hit;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adc_avg_fifo dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .flush        (flush),
      .avg_log2     (avg_log2),
      .threshold    (threshold),
`ifdef ADC_AVG_WINDOW_EN
      .threshold_lo (threshold_lo),
      .win_hit      (win_hit),
`endif
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .overflow     (overflow),
      .thr_hit      (thr_hit),
      .avg_busy     (avg_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      step();
      sample_valid = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; flush = 1'b0; sample_valid = 1'b0; rd_en = 1'b0;
      avg_log2 = 3'd0; threshold = 12'h800; sample_data = '0;
`ifdef ADC_AVG_WINDOW_EN
      threshold_lo = 12'h200;
`endif
      step();
      step();
      chk("rst_rd_data", rd_data, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_thr_hit", thr_hit, 0);
      chk("rst_avg_busy", avg_busy, 0);
      rst_n = 1'b1;
      en    = 1'b1;
      step();

      // Test 1: k=0, immediate pushes, threshold pulse
      send(12'h123);
      chk("t1_level1", level, 1);
      chk("t1_head1", rd_data, 12'h123);
      chk("t1_thr_lo", thr_hit, 0);
`ifdef ADC_AVG_WINDOW_EN
      chk("t1_win_below", win_hit, 1);
`endif
      send(12'h900);
      chk("t1_level2", level, 2);
      chk("t1_head2", rd_data, 12'h123);
      chk("t1_thr_hi", thr_hit, 1);
      step();
      chk("t1_thr_pulse_end", thr_hit, 0);
      pop();
      chk("t1_pop_head", rd_data, 12'h900);
      pop();
      chk("t1_empty", empty, 1);
      chk("t1_rd_zero", rd_data, 0);

      // Test 2: k=2 average of 0x100,0x200,0x300,0x401
      avg_log2 = 3'd2;
      send(12'h100);
      chk("t2_busy1", avg_busy, 1);
      send(12'h200);
      chk("t2_busy2", avg_busy, 1);
      send(12'h300);
      chk("t2_busy3", avg_busy, 1);
      chk("t2_no_push", empty, 1);
      send(12'h401);
      chk("t2_busy_done", avg_busy, 0);
      chk("t2_level", level, 1);
      chk("t2_result", rd_data, 12'h280);
      chk("t2_thr", thr_hit, 0);
      pop();

      // Empty-FIFO pops and empty push+pop
      pop();
      chk("pop_empty_level", level, 0);
      chk("pop_empty_flag", empty, 1);
      avg_log2 = 3'd0;
      rd_en = 1'b1;
      send(12'h055);
      rd_en = 1'b0;
      chk("empty_pushpop_level", level, 1);
      chk("empty_pushpop_head", rd_data, 12'h055);
      pop();

      // Tests 3/4: fill, push+pop when full, then overflow
      for (int i = 1; i <= 8; i++) send(DW'(i));
      chk("t3_full", full, 1);
      chk("t3_level8", level, 8);
      chk("t3_no_ovf", overflow, 0);
      rd_en = 1'b1;
      send(12'h0AA);
      rd_en = 1'b0;
      chk("t4_level", level, 8);
      chk("t4_no_ovf", overflow, 0);
      chk("t4_head", rd_data, 2);
      send(12'hA00);
      chk("t3_ovf", overflow, 1);
      chk("t3_thr_suppressed", thr_hit, 0);
      chk("t3_level_kept", level, 8);
      for (int i = 2; i <= 8; i++) begin
         chk("t3_pop_order", rd_data, i);
         pop();
      end
      chk("t4_pop_last", rd_data, 12'h0AA);
      pop();
      chk("t3_empty", empty, 1);
      chk("t3_not_full", full, 0);
      chk("t3_ovf_sticky", overflow, 1);

      // Test 5: en drop discards partial sum; avg_log2 change mid-block ignored
      avg_log2 = 3'd3;
      for (int i = 0; i < 3; i++) send(12'h100);
      chk("t5_busy", avg_busy, 1);
      en = 1'b0;
      step();
      chk("t5_en_clear", avg_busy, 0);
      en = 1'b1;
      send(12'h010);
      avg_log2 = 3'd0;
      for (int i = 0; i < 6; i++) send(12'h010);
      chk("t5_no_early", empty, 1);
      send(12'h010);
      chk("t5_level", level, 1);
      chk("t5_result", rd_data, 12'h010);
      pop();

      // Test 6: flush with coincident sample, 3 entries held and overflow set
      for (int i = 0; i < 3; i++) send(12'h0F0);
      chk("t6_level3", level, 3);
      avg_log2 = 3'd2;
      send(12'h100);
      chk("t6_busy", avg_busy, 1);
      flush = 1'b1;
      send(12'h100);
      flush = 1'b0;
      chk("t6_level", level, 0);
      chk("t6_empty", empty, 1);
      chk("t6_ovf_clr", overflow, 0);
      chk("t6_busy_clr", avg_busy, 0);
      for (int i = 0; i < 3; i++) send(12'h040);
      chk("t6_not_counted", empty, 1);
      send(12'h040);
      chk("t6_result", rd_data, 12'h040);

      // Asynchronous reset mid-operation
      send(12'h100);
      chk("ar_pre_busy", avg_busy, 1);
      chk("ar_pre_level", level, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_level", level, 0);
      chk("ar_empty", empty, 1);
      chk("ar_rd_data", rd_data, 0);
      chk("ar_busy", avg_busy, 0);
      chk("ar_full", full, 0);
      chk("ar_thr", thr_hit, 0);
      step();
      rst_n = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
